// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding, default line timing and
// the baud divider calculation used by both the tx and rx stages.
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ  = 50_000_000;
  localparam int unsigned DEF_BAUD_RATE = 9600;
  localparam int unsigned DATA_W        = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef logic [DATA_W-1:0] uart_byte_t;

  // Clock cycles per bit period.
  function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead byte FIFO: the head entry is visible on rd_data_c
// whenever the FIFO is not empty. DEPTH must be a power of two, minimum 2.
module uart_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  uart_byte_t       wr_data,
  input  logic             rd_en,
  output uart_byte_t       rd_data_c,
  output logic             full_c,
  output logic             empty_c,
  output logic [CNT_W-1:0] count
);

  uart_byte_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_wr;
  logic             do_rd;

  assign full_c    = (cnt_q == CNT_W'(DEPTH));
  assign empty_c   = (cnt_q == '0);
  assign count     = cnt_q;
  assign rd_data_c = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    do_wr    = wr_en && !full_c;
    do_rd    = rd_en && !empty_c;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: bytes queue in uart_fifo and are serialized
// back-to-back on tx. Define UART_TX_PARITY_EN to add an even parity bit.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter  int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter  int unsigned BAUD_RATE  = DEF_BAUD_RATE,
  parameter  int unsigned FIFO_DEPTH = 16,
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [7:0]       pi_data,
  input  logic             pi_flag,
  output logic             pi_ready,
  output logic             tx,
  output logic             tx_busy,
  output logic [CNT_W-1:0] fifo_cnt,
  output logic             ovf
);

  localparam int unsigned BAUD_MAX = baud_cnt_max(CLK_FREQ, BAUD_RATE);
  localparam int unsigned BAUD_W   = (BAUD_MAX > 1) ? $clog2(BAUD_MAX) : 1;

  logic [2:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  uart_byte_t        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              tx_busy_q, tx_busy_d;
  logic              pi_ready_q, pi_ready_d;
  logic              ovf_q, ovf_d;

  logic              baud_last;
  logic [2:0]        bit_nxt;
  logic              pop;
  logic              fifo_wr;
  logic [CNT_W-1:0]  cnt_nxt;
  uart_byte_t        head_c;
  logic              full_c;
  logic              empty_c;

  assign fifo_wr = pi_flag && pi_ready_q && !full_c;

  uart_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .wr_en     (fifo_wr),
    .wr_data   (pi_data),
    .rd_en     (pop),
    .rd_data_c (head_c),
    .full_c    (full_c),
    .empty_c   (empty_c),
    .count     (fifo_cnt)
  );

  assign baud_last = (baud_cnt_q == BAUD_W'(BAUD_MAX - 1));
  assign bit_nxt   = bit_idx_q + 3'd1;

  // Serializer; tx_d is the line level for the state being entered so tx stays registered.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d      = 1'b1;
        tx_busy_d = 1'b0;
        if (!empty_c) begin
          pop        = 1'b1;
          shift_d    = head_c;
          state_d    = ST_START;
          baud_cnt_d = '0;
          tx_d       = 1'b0;
          tx_busy_d  = 1'b1;
        end
      end
      ST_START: begin
        baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        if (baud_last) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = ST_DATA;
          tx_d       = shift_q[0];
        end
      end
      ST_DATA: begin
        baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        if (baud_last) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = ^shift_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_nxt;
            tx_d      = shift_q[bit_nxt];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        if (baud_last) begin
          baud_cnt_d = '0;
          state_d    = ST_STOP;
          tx_d       = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        if (baud_last) begin
          baud_cnt_d = '0;
          // Chain straight into the next start bit so queued bytes leave gap-free.
          if (!empty_c) begin
            pop     = 1'b1;
            shift_d = head_c;
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d   = ST_IDLE;
            tx_d      = 1'b1;
            tx_busy_d = 1'b0;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        tx_busy_d  = 1'b0;
      end
    endcase
  end

  // pi_ready tracks next-cycle occupancy, so a pop while full frees space one cycle later.
  always_comb begin
    cnt_nxt    = fifo_cnt + CNT_W'(fifo_wr) - CNT_W'(pop);
    pi_ready_d = (cnt_nxt != CNT_W'(FIFO_DEPTH));
    ovf_d      = pi_flag && !pi_ready_q;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      pi_ready_q <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      pi_ready_q <= pi_ready_d;
      ovf_q      <= ovf_d;
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = tx_busy_q;
  assign pi_ready = pi_ready_q;
  assign ovf      = ovf_q;

endmodule
